// File: rtl/warp_fetch_sched_if.sv
// Fetch-scheduler bus: warp launch/retire, stall mask, fetch handshake and
// status outputs. The scheduler uses the slave modport, its driver the master.
interface warp_fetch_sched_if #(
    parameter int NUM_WARPS = 32,
    parameter int WID_W     = $clog2(NUM_WARPS),
    parameter int CNT_W     = 16
);
    logic                 launch_valid;
    logic [WID_W-1:0]     launch_wid;
    logic                 retire_valid;
    logic [WID_W-1:0]     retire_wid;
    logic [NUM_WARPS-1:0] warp_stall;
    logic                 fetch_ready;
    logic                 imem_valid;
    logic                 fetch_enable;
    logic [WID_W-1:0]     fetch_warp_id;
    logic [NUM_WARPS-1:0] active_mask;
    logic [CNT_W-1:0]     grant_count;
    logic                 timeout_err;

    modport master (
        output launch_valid, launch_wid, retire_valid, retire_wid,
               warp_stall, fetch_ready, imem_valid,
        input  fetch_enable, fetch_warp_id, active_mask, grant_count, timeout_err
    );

    modport slave (
        input  launch_valid, launch_wid, retire_valid, retire_wid,
               warp_stall, fetch_ready, imem_valid,
        output fetch_enable, fetch_warp_id, active_mask, grant_count, timeout_err
    );
endinterface

// File: rtl/warp_fetch_sched.sv
// Warp fetch scheduler: tracks active warps, round-robin arbitrates the
// instruction-fetch port among eligible warps and holds one request open
// until the instruction memory answers.
// Optional macro FETCH_TIMEOUT_EN adds a watchdog on the outstanding fetch
// that abandons it after TIMEOUT_CYCLES and raises a sticky timeout_err.
module warp_fetch_sched #(
    parameter int NUM_WARPS      = 32,
    parameter int WID_W          = $clog2(NUM_WARPS),
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst,
    warp_fetch_sched_if.slave  bus
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t               r_state;
    logic [NUM_WARPS-1:0] r_active;
    logic [WID_W-1:0]     r_last;
    logic [WID_W-1:0]     r_wid;
    logic                 r_en;
    logic [CNT_W-1:0]     r_cnt;

    logic [NUM_WARPS-1:0] w_retire_clr;
    logic [NUM_WARPS-1:0] w_launch_set;
    logic [NUM_WARPS-1:0] w_eligible;
    logic [WID_W-1:0]     w_winner;
    logic [WID_W-1:0]     w_idx;
    logic                 w_any;

`ifdef FETCH_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0]    r_tcnt;
    logic                 r_err;
`endif

    // Decode launch/retire pulses into one-hot masks.
    always_comb begin
        w_retire_clr = '0;
        w_launch_set = '0;
        if (bus.retire_valid) w_retire_clr[bus.retire_wid] = 1'b1;
        if (bus.launch_valid) w_launch_set[bus.launch_wid] = 1'b1;
    end

    // Active mask: retire clears first, so a same-cycle launch of that warp wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_active <= '0;
        else     r_active <= (r_active & ~w_retire_clr) | w_launch_set;
    end

    assign w_eligible = r_active & ~bus.warp_stall;

    // Round-robin pick: scan upward from last_grant+1; WID_W arithmetic wraps
    // naturally since NUM_WARPS is a power of two.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_WARPS; k++) begin
            w_idx = r_last + WID_W'(k);
            if (!w_any && w_eligible[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Fetch FSM: grant in IDLE, hold the request in WAIT until the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_wid   <= '0;
            r_last  <= WID_W'(NUM_WARPS - 1);
            r_cnt   <= '0;
`ifdef FETCH_TIMEOUT_EN
            r_tcnt  <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any && bus.fetch_ready) begin
                        r_en    <= 1'b1;
                        r_wid   <= w_winner;
                        r_last  <= w_winner;
                        r_state <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // Stall/retire/backpressure never cancel the in-flight request.
                    if (bus.imem_valid) begin
                        r_en    <= 1'b0;
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= S_IDLE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else begin
                        r_tcnt <= r_tcnt + 1'b1;
                        // This edge brings the counter to TIMEOUT_CYCLES.
                        if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                            r_err   <= 1'b1;
                            r_en    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_enable  = r_en;
    assign bus.fetch_warp_id = r_wid;
    assign bus.active_mask   = r_active;
    assign bus.grant_count   = r_cnt;
`ifdef FETCH_TIMEOUT_EN
    assign bus.timeout_err   = r_err;
`else
    assign bus.timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_warp_fetch_sched.sv
// Bench for warp_fetch_sched: a cycle model of the scheduling rules checked
// against the DUT every falling edge, plus directed scenarios with literal
// expectations on grant order, counts and masks.
module tb_warp_fetch_sched;
    localparam int NW = 8;
    localparam int WW = 3;
    localparam int CW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    warp_fetch_sched_if #(.NUM_WARPS(NW), .WID_W(WW), .CNT_W(CW)) bus ();

    warp_fetch_sched #(.NUM_WARPS(NW), .WID_W(WW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_act [NW];
    bit m_busy;
    int m_wid, m_last, m_cnt, m_tmr;
    bit m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_act[i]) m_act[i] = 1'b0;
            m_busy = 0; m_wid = 0; m_last = NW - 1; m_cnt = 0; m_tmr = 0; m_err = 0;
        end else begin
            if (!m_busy) begin
                if (bus.fetch_ready) begin
                    bit found;
                    found = 0;
                    for (int off = 1; off <= NW; off++) begin
                        int w;
                        w = (m_last + off) % NW;
                        if (!found && m_act[w] && !bus.warp_stall[w]) begin
                            found = 1; m_busy = 1; m_wid = w; m_last = w; m_tmr = 0;
                        end
                    end
                end
            end else if (bus.imem_valid) begin
                m_busy = 0;
                m_cnt  = (m_cnt + 1) % (1 << CW);
            end else begin
`ifdef FETCH_TIMEOUT_EN
                m_tmr++;
                if (m_tmr == TO) begin
                    m_err  = 1;
                    m_busy = 0;
                end
`endif
            end
            if (bus.retire_valid) m_act[bus.retire_wid] = 1'b0;
            if (bus.launch_valid) m_act[bus.launch_wid] = 1'b1;
        end
    end

    // ---------------- compare + grant log ----------------
    int  glog[$];
    logic prev_en;

    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
        end else begin
            logic [NW-1:0] mm;
            for (int i = 0; i < NW; i++) mm[i] = m_act[i];
            chk("model_fetch_enable", bus.fetch_enable, m_busy);
            chk("model_fetch_warp_id", bus.fetch_warp_id, m_wid);
            chk("model_active_mask", bus.active_mask, mm);
            chk("model_grant_count", bus.grant_count, m_cnt);
            chk("model_timeout_err", bus.timeout_err, m_err);
            if (bus.fetch_enable && !prev_en) glog.push_back(int'(bus.fetch_warp_id));
            prev_en = bus.fetch_enable;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic clear_inputs();
        bus.launch_valid = 0; bus.launch_wid = '0;
        bus.retire_valid = 0; bus.retire_wid = '0;
        bus.warp_stall = '0; bus.fetch_ready = 0; bus.imem_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        glog.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic launch(input int w);
        bus.launch_valid = 1; bus.launch_wid = WW'(w);
        tick();
        bus.launch_valid = 0;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int c = 0;
        while (glog.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk("grant_wait_budget", glog.size() >= n, 1);
    endtask

    task automatic chk_log(input string nm, input int exp[$]);
        chk({nm, "_len"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < glog.size(); i++)
            chk(nm, glog[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();

        // Reset state
        do_reset();
        chk("rst_fetch_enable", bus.fetch_enable, 0);
        chk("rst_fetch_warp_id", bus.fetch_warp_id, 0);
        chk("rst_active_mask", bus.active_mask, 0);
        chk("rst_grant_count", bus.grant_count, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);

        // Round robin over 0,1,2 with backpressure first; imem_valid in IDLE ignored
        bus.imem_valid = 1;
        launch(0); launch(1); launch(2);
        tick(); tick();
        chk("bp_fetch_enable", bus.fetch_enable, 0);
        chk("bp_grant_count", bus.grant_count, 0);
        chk("bp_active_mask", bus.active_mask, 8'h07);
        bus.fetch_ready = 1;
        tick();
        chk("first_issue_enable", bus.fetch_enable, 1);
        chk("first_issue_wid", bus.fetch_warp_id, 0);
        repeat (9) tick();
        chk("rr_grant_count", bus.grant_count, 5);
        chk_log("rr_seq", '{0, 1, 2, 0, 1});

        // Stall mask skips warp 1, then it regains its turn
        do_reset();
        bus.imem_valid = 1;
        launch(0); launch(1); launch(2); launch(3);
        bus.fetch_ready = 1;
        wait_grants(1, 4);
        bus.warp_stall = 8'h02;
        wait_grants(4, 20);
        bus.warp_stall = '0;
        wait_grants(5, 10);
        chk_log("stall_seq", '{0, 2, 3, 0, 1});

        // Retire of the in-flight warp; same-cycle launch+retire
        do_reset();
        launch(5); launch(6);
        bus.fetch_ready = 1;
        wait_grants(1, 4);
        bus.retire_valid = 1; bus.retire_wid = 3'd5;
        tick();
        bus.retire_valid = 0;
        tick(); tick();
        chk("retire_still_waiting", bus.fetch_enable, 1);
        bus.imem_valid = 1;
        tick();
        chk("retire_completed_count", bus.grant_count, 1);
        chk("retire_completed_en", bus.fetch_enable, 0);
        wait_grants(4, 20);
        chk_log("retire_seq", '{5, 6, 6, 6});
        chk("retire_mask", bus.active_mask, 8'h40);
        bus.launch_valid = 1; bus.launch_wid = 3'd7;
        bus.retire_valid = 1; bus.retire_wid = 3'd7;
        tick();
        bus.launch_valid = 0; bus.retire_valid = 0;
        chk("same_cycle_mask", bus.active_mask, 8'hC0);

`ifdef FETCH_TIMEOUT_EN
        // Watchdog abandons a request after TO WAIT cycles
        do_reset();
        launch(1); launch(2);
        bus.fetch_ready = 1;
        wait_grants(1, 4);
        repeat (TO - 1) tick();
        chk("to_before_en", bus.fetch_enable, 1);
        chk("to_before_err", bus.timeout_err, 0);
        tick();
        chk("to_err", bus.timeout_err, 1);
        chk("to_en_drop", bus.fetch_enable, 0);
        chk("to_count", bus.grant_count, 0);
        tick();
        chk("to_next_en", bus.fetch_enable, 1);
        chk("to_next_wid", bus.fetch_warp_id, 2);
        bus.imem_valid = 1;
        repeat (4) tick();
        chk("to_sticky", bus.timeout_err, 1);
`endif

        // Asynchronous reset in the middle of WAIT
        do_reset();
        bus.imem_valid = 1;
        launch(3); launch(0);
        bus.fetch_ready = 1;
        wait_grants(2, 10);
        chk_log("pre_rst_seq", '{0, 3});
        bus.imem_valid = 0;
        tick();
        chk("pre_rst_wait", bus.fetch_enable, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_en", bus.fetch_enable, 0);
        chk("async_rst_mask", bus.active_mask, 0);
        chk("async_rst_count", bus.grant_count, 0);
        clear_inputs();
        glog.delete();
        tick();
        rst = 1'b0;
        tick();
        bus.imem_valid = 1;
        launch(3); launch(0);
        bus.fetch_ready = 1;
        wait_grants(1, 4);
        chk_log("post_rst_seq", '{0});
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/warp_fetch_sched.md
Name: warp_fetch_sched

Overview:
- Selects which warp owns the SM instruction-fetch port each fetch slot.
- Sits between the warp launch/retire logic and the fetch unit.
- Keeps a per-warp active mask and does round-robin arbitration over eligible warps (active, not stalled).
- Holds one fetch request open until the instruction memory responds, and respects fetch-queue backpressure.

Parameters:
- NUM_WARPS, 32, number of warp slots; power of two, at least 2.
- WID_W, $clog2(NUM_WARPS), warp-id width.
- TIMEOUT_CYCLES, 64, watchdog limit for one outstanding fetch. Used only with FETCH_TIMEOUT_EN.
- CNT_W, 16, width of the grant performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- launch_valid  in  1  pulse; sets the active bit of launch_wid.
- launch_wid  in  WID_W  warp being launched.
- retire_valid  in  1  pulse; clears the active bit of retire_wid.
- retire_wid  in  WID_W  warp being retired.
- warp_stall  in  NUM_WARPS  level mask; 1 = warp ineligible this cycle (scoreboard/branch).
- fetch_ready  in  1  fetch queue can accept one more instruction.
- imem_valid  in  1  instruction memory response for the outstanding request.
- fetch_enable  out  1  registered; request outstanding to the fetch unit.
- fetch_warp_id  out  WID_W  registered; warp id of the outstanding request.
- active_mask  out  NUM_WARPS  current active bits.
- grant_count  out  CNT_W  number of completed fetches; wraps.
- timeout_err  out  1  sticky watchdog flag. Constant 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (asynchronous, immediate):
  - fetch_enable=0, fetch_warp_id=0, active_mask=0, grant_count=0, timeout_err=0.
  - State IDLE; last_grant=NUM_WARPS-1, so warp 0 wins the first arbitration.
- Active mask update, every cycle:
  - The retire clear is applied before the launch set.
  - If launch and retire name the same wid in the same cycle, that warp ends active.
- Eligibility: eligible[i] = active_mask[i] & ~warp_stall[i]. Uses the registered active_mask; a launch becomes eligible the cycle after launch_valid.
- Arbitration: search from (last_grant+1) mod NUM_WARPS upward with wrap; the first eligible warp wins.
- State IDLE:
  - If any warp is eligible and fetch_ready=1: on the next edge fetch_enable<=1, fetch_warp_id<=winner, last_grant<=winner, go to WAIT.
  - Otherwise stay in IDLE with fetch_enable=0.
- State WAIT:
  - fetch_enable stays 1 and fetch_warp_id stays stable.
  - warp_stall, retire and fetch_ready changes do not cancel the in-flight request.
  - On imem_valid=1: fetch_enable<=0, grant_count<=grant_count+1 (wraps), go to IDLE.
- Issue rate:
  - Minimum request-to-request spacing is 2 cycles: grant edge, then response.
  - With an immediate response the maximum rate is one fetch every 2 cycles.
  - imem_valid in the same cycle as the grant edge does not count; the response is sampled only in WAIT.
- imem_valid while in IDLE: ignored; no count change.
- Retire of the in-flight warp: the request still completes and is counted. The warp is not granted again until it is re-launched.
- No eligible warps: stay in IDLE; last_grant is unchanged.
- Single eligible warp: re-granted every slot.
- Reset mid-WAIT: the request is abandoned immediately and fetch_enable drops asynchronously.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- When defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to WAIT and increments each WAIT cycle without imem_valid.
  - When the counter reaches TIMEOUT_CYCLES: set timeout_err (sticky until rst), fetch_enable<=0, go to IDLE, grant_count unchanged.
  - imem_valid in the same cycle as the limit is hit counts as a normal completion; no error.
- When undefined: no counter is instantiated, WAIT waits indefinitely, and timeout_err is tied to 0.

Test Plan:
- Launch warps 0,1,2; stall=0; fetch_ready=1; imem_valid=1 every WAIT cycle -> fetch_warp_id sequence 0,1,2,0,1 with fetch_enable high on alternate cycles; grant_count=5 after 10 cycles.
- Warps 0–3 active, warp_stall=4'b0010 after warp 0 is granted -> next grants are 2, 3, 0 (1 skipped); clearing the stall -> warp 1 granted in its round-robin turn.
- fetch_ready=0 with warps active -> fetch_enable stays 0 and grant_count stays 0; raising fetch_ready -> request issues on the next edge.
- Warp 5 in WAIT, retire_valid wid=5, imem_valid three cycles later -> request completes and grant_count increments; warp 5 is never granted again until relaunch. Same-cycle launch+retire of wid 7 -> active_mask[7]=1.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=8, hold imem_valid=0 -> after 8 WAIT cycles timeout_err=1, fetch_enable=0, next eligible warp granted; timeout_err stays 1 until rst.
- Assert rst during WAIT -> fetch_enable=0 and active_mask=0 immediately; after release the first grant goes to warp 0.
